// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and stream constants for the instruction-memory loader.
package imem_loader_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;
   localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs MSB-first bytes into 32-bit words, pulsing word_valid on the completing byte.
module imem_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);
   logic [23:0] r_sh;
   logic [1:0]  r_idx;
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_sh  <= '0;
         r_idx <= '0;
      end else if (byte_en) begin
         r_sh  <= {r_sh[15:0], byte_in};
         r_idx <= r_idx + 2'd1;
      end
   end
   // the completing byte is forwarded directly so the word is ready on its own handshake
   assign word       = {r_sh, byte_in};
   assign word_valid = byte_en && (r_idx == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader driving the instruction RAM write port and holding the core in reset.
// Optional trailing XOR checksum with CHECK/ERR states is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);
   state_t              r_state, w_next;
   logic                w_hs, w_wv, w_last;
   logic [31:0]         w_word;
   logic [ADDR_W-1:0]   r_cnt, r_last, r_waddr;
   logic                r_we;
   logic [31:0]         r_wdata;

   assign in_ready = (r_state == IDLE) || (r_state == LOAD) || (r_state == CHECK);
   assign w_hs     = in_valid && in_ready;
   assign w_last   = w_wv && (r_cnt == r_last);

   imem_word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (r_state != LOAD),
      .byte_en    (w_hs && (r_state == LOAD)),
      .byte_in    (in_data),
      .word       (w_word),
      .word_valid (w_wv)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] r_xor;
   always_ff @(posedge clk) begin
      if (reset)
         r_xor <= '0;
      else if (w_hs && r_state == IDLE)
         r_xor <= in_data;
      else if (w_hs && r_state == LOAD)
         r_xor <= r_xor ^ in_data;
   end
   assign load_err = (r_state == ERR);
`else
   assign load_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  w_next = w_hs ? LOAD : IDLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
         LOAD:  w_next = w_last ? CHECK : LOAD;
         CHECK: w_next = w_hs ? ((in_data == r_xor) ? DONE : ERR) : CHECK;
         ERR:   w_next = start ? IDLE : ERR;
`else
         LOAD:  w_next = w_last ? DONE : LOAD;
`endif
         DONE:  w_next = start ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end

   // N-1 in ADDR_W bits: a count that is 0 mod DEPTH wraps naturally to DEPTH-1
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_last  <= '0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= w_wv;
         if (w_hs && r_state == IDLE) begin
            r_cnt  <= '0;
            r_last <= in_data[ADDR_W-1:0] - ADDR_W'(1);
         end else if (w_wv) begin
            r_cnt   <= r_cnt + ADDR_W'(1);
            r_waddr <= r_cnt;
            r_wdata <= w_word;
         end
      end
   end

   assign mem_we    = r_we;
   assign mem_waddr = r_waddr;
   assign mem_wdata = r_wdata;
   // done is withheld during the final write pulse so the core is released only after it lands
   assign load_done = (r_state == DONE) && !r_we;
   assign cpu_hold  = !load_done;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader on the write side of the instruction memory.
- Accepts a byte stream (valid/ready), assembles big-endian 32-bit words and drives a synchronous write port into instruction RAM.
- Holds the processor core in reset until the image is fully written.
- Sits between a host byte source (UART receiver or testbench) and the instruction RAM write port.

Parameters:
ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W words (64 by default); legal range 1..8.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  byte on in_data is valid.
in_data  input  8  stream byte.
in_ready  output  1  loader can accept a byte this cycle.
start  input  1  single-cycle pulse; re-arms the loader from DONE or ERR.
mem_we  output  1  write strobe to instruction RAM.
mem_waddr  output  ADDR_W  word address for the write.
mem_wdata  output  32  word to write.
cpu_hold  output  1  holds the processor core in reset while high.
load_done  output  1  image fully written.
load_err  output  1  checksum mismatch (only with the optional feature).

Behaviour:
- A byte transfers on any cycle where in_valid && in_ready are both high. in_data is sampled on that edge.
- Reset values: state=IDLE, in_ready=1, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, byte index=0, word counter=0.
- Stream format:
  - Byte 0 is the word count N. N=0 means DEPTH words. For N>DEPTH, the loader uses N mod DEPTH, with 0 mapping to DEPTH.
  - The count byte is followed by 4*N data bytes. Each word is sent MSB first.
- States:
  - IDLE: in_ready=1. On handshake, latch N, clear the word counter and byte index, then go to LOAD.
  - LOAD: in_ready=1.
    - Handshakes shift bytes into a 32-bit assembly register: bytes 0..3 map to [31:24], [23:16], [15:8], [7:0].
    - On the 4th byte's handshake at cycle t, at t+1: mem_we=1 for exactly one cycle, mem_waddr=word counter, mem_wdata=assembled word.
    - The word counter increments at t+1. Back-to-back bytes on consecutive cycles are sustained with no stall.
    - When the 4th byte of word N-1 transfers, go to DONE (or CHECK with the feature).
  - DONE: in_ready=0.
    - load_done=1 and cpu_hold=0 from the cycle after the final mem_we pulse.
    - start: go to IDLE, clear load_done, set cpu_hold=1 on the next edge.
  - ERR (feature only): in_ready=0, load_err=1, cpu_hold stays 1. start goes to IDLE and clears load_err.
- start is ignored in IDLE and LOAD.
- in_valid while in_ready=0 is not consumed; the source must hold the byte.
- Address wrap: mem_waddr never exceeds N-1 ≤ DEPTH-1. When N=DEPTH, the final write is to address DEPTH-1 and the counter wraps to 0 without error.
- Reset mid-load: the loader returns to IDLE on the next edge. A partially assembled word is discarded with no mem_we. Words already written remain in RAM. cpu_hold=1.
- mem_we is never asserted outside the single cycle following a word-completing handshake.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers the count byte and all data bytes.
  - After the last data byte, state CHECK accepts one more byte, with in_ready=1.
  - If that byte equals the running XOR, go to DONE. Otherwise go to ERR.
  - load_done (or load_err) asserts the cycle after the checksum handshake. cpu_hold releases only on DONE.
- Undefined:
  - No CHECK or ERR states.
  - load_err is tied to 0.
  - The stream ends at the last data byte.

Decomposition:
- Package imem_loader_pkg: state enum (IDLE, LOAD, CHECK, DONE, ERR) and the constant BYTES_PER_WORD=4.
- One sub-module, imem_word_assembler: shift register plus 2-bit byte index, with outputs word[31:0] and word_valid pulse.
  - The top holds the FSM, word counter, registered write port and optional checksum.

Test Plan:
1. Reset, then stream 02, 20 08 00 05, 8C 09 00 04 -> mem_we pulses twice: addr 0 = 0x20080005, addr 1 = 0x8C090004. load_done=1 and cpu_hold=0 one cycle after the 2nd pulse.
2. Count 00 plus 256 bytes, addr i holding i → 64 writes at addr 0..63, with mem_wdata==i. No write beyond 63. load_done=1.
3. Random in_valid gaps plus one back-to-back burst → write data and addresses are unchanged vs. the gapless run. Exactly one mem_we per word.
4. Reset asserted after 3 data bytes of word 1 → no mem_we for word 1. State returns to IDLE, cpu_hold=1. A new stream 01, DEADBEEF writes 0xDEADBEEF at addr 0.
5. In DONE: in_valid held high → in_ready=0, no writes. start pulse → load_done=0 and cpu_hold=1 the next cycle. A reload succeeds.
6. With IMEM_LOADER_CHECKSUM_EN, stream 01, 11 22 33 44, then checksum:
   - Checksum 0x45 → DONE.
   - Checksum 0x00 → load_err=1 and cpu_hold stays 1. start clears load_err.
